// File: rtl/sh_mem_rr_pkg.sv
// Shared definitions for the banked shared memory: default parameter values,
// the per-core {wr, rd} request encoding and small decode helpers.
package sh_mem_rr_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_REG_SIZE  = 8;
    localparam int DEF_WORD_W    = 8;

    // Per-core request encoding on the flat enable bus; both bits set means write.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } op_e;

    function automatic logic op_is_write(input logic [1:0] en);
        return en[1];
    endfunction

    function automatic logic op_is_read(input logic [1:0] en);
        return en == OP_RD;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sh_mem_rr_bank.sv
// One scratchpad bank: un-reset storage array with synchronous write and a
// registered read port that clears on reset.
module sh_bank_p #(
    parameter int REG_SIZE = 8,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                re,
    input  logic [WORD_W-1:0]   addr,
    input  logic [REG_SIZE-1:0] wdata,
    output logic [REG_SIZE-1:0] rdata
);

    logic [REG_SIZE-1:0] mem [2**WORD_W];
    logic [REG_SIZE-1:0] rdata_q;
    logic [REG_SIZE-1:0] rdata_d;

    // A write landing on the same edge as reset assertion must not modify the array.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sh_mem_rr.sv
// Multi-bank shared memory with independent per-bank round-robin arbitration.
// Define SH_MEM_BCAST_EN to let identical same-word reads complete alongside the winner.
module sh_mem_rr
    import sh_mem_rr_pkg::*;
#(
    parameter  int NUM_CORES = DEF_NUM_CORES,
    parameter  int NUM_BANKS = DEF_NUM_BANKS,
    parameter  int REG_SIZE  = DEF_REG_SIZE,
    parameter  int WORD_W    = DEF_WORD_W,
    localparam int BANK_ID_W = id_width(NUM_BANKS),
    localparam int CORE_ID_W = $clog2(NUM_CORES),
    localparam int ADDR_SIZE = BANK_ID_W + WORD_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]        enable,
    input  logic [ADDR_SIZE*NUM_CORES-1:0] addr,
    input  logic [REG_SIZE*NUM_CORES-1:0] wr_data,
    output logic [REG_SIZE*NUM_CORES-1:0] rd_data,
    output logic [NUM_CORES-1:0]          ready
);

    logic [BANK_ID_W-1:0] core_bank  [NUM_CORES];
    logic [WORD_W-1:0]    core_word  [NUM_CORES];
    logic [REG_SIZE-1:0]  core_wdata [NUM_CORES];
    logic                 core_wr    [NUM_CORES];
    logic                 core_rd    [NUM_CORES];
    logic                 core_act   [NUM_CORES];

    logic [NUM_CORES-1:0] req_mask  [NUM_BANKS];
    logic                 grant_vld [NUM_BANKS];
    logic [CORE_ID_W-1:0] grant_idx [NUM_BANKS];
    logic [CORE_ID_W-1:0] last_q    [NUM_BANKS];
    logic [CORE_ID_W-1:0] last_d    [NUM_BANKS];

    logic                 bank_we    [NUM_BANKS];
    logic                 bank_re    [NUM_BANKS];
    logic [WORD_W-1:0]    bank_addr  [NUM_BANKS];
    logic [REG_SIZE-1:0]  bank_wdata [NUM_BANKS];
    logic [REG_SIZE-1:0]  bank_rdata [NUM_BANKS];

    logic [NUM_CORES-1:0] ready_q;
    logic [NUM_CORES-1:0] ready_d;
    logic [BANK_ID_W-1:0] bank_id_q [NUM_CORES];
    logic [BANK_ID_W-1:0] bank_id_d [NUM_CORES];
    logic                 is_rd_q   [NUM_CORES];
    logic                 is_rd_d   [NUM_CORES];

    // Returns {found, winner}; the search starts one past the last winner and wraps.
    function automatic logic [CORE_ID_W:0] rr_pick(
        input logic [NUM_CORES-1:0] mask,
        input logic [CORE_ID_W-1:0] last
    );
        logic                 found;
        logic [CORE_ID_W-1:0] pick;
        int                   idx;
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx = (int'(last) + i) % NUM_CORES;
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = CORE_ID_W'(idx);
            end
        end
        return {found, pick};
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            core_bank[c]  = addr[c*ADDR_SIZE+WORD_W +: BANK_ID_W];
            core_word[c]  = addr[c*ADDR_SIZE +: WORD_W];
            core_wdata[c] = wr_data[c*REG_SIZE +: REG_SIZE];
            core_wr[c]    = op_is_write(enable[2*c +: 2]);
            core_rd[c]    = op_is_read(enable[2*c +: 2]);
            core_act[c]   = core_wr[c] || core_rd[c];
        end
    end

    // Cores showing ready this cycle sit out, which enforces one access per two cycles.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_mask[b] = '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                req_mask[b][c] = core_act[c] && !ready_q[c]
                              && (core_bank[c] == BANK_ID_W'(b));
            end
            {grant_vld[b], grant_idx[b]} = rr_pick(req_mask[b], last_q[b]);
            last_d[b]     = grant_vld[b] ? grant_idx[b] : last_q[b];
            bank_we[b]    = grant_vld[b] && core_wr[grant_idx[b]];
            bank_re[b]    = grant_vld[b] && core_rd[grant_idx[b]];
            bank_addr[b]  = core_word[grant_idx[b]];
            bank_wdata[b] = core_wdata[grant_idx[b]];
        end
    end

    always_comb begin
        ready_d = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            bank_id_d[c] = bank_id_q[c];
            is_rd_d[c]   = is_rd_q[c];
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_vld[b]) begin
                ready_d[grant_idx[b]] = 1'b1;
`ifdef SH_MEM_BCAST_EN
                // Pending reads of the winner's word share its bank read; pointer stays with the winner.
                if (core_rd[grant_idx[b]]) begin
                    for (int c = 0; c < NUM_CORES; c++) begin
                        if (req_mask[b][c] && core_rd[c]
                            && (core_word[c] == core_word[grant_idx[b]])) begin
                            ready_d[c] = 1'b1;
                        end
                    end
                end
`endif
            end
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            if (ready_d[c]) begin
                bank_id_d[c] = core_bank[c];
                is_rd_d[c]   = core_rd[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                last_q[b] <= CORE_ID_W'(NUM_CORES - 1);
            end
            for (int c = 0; c < NUM_CORES; c++) begin
                bank_id_q[c] <= '0;
                is_rd_q[c]   <= 1'b0;
            end
        end else begin
            ready_q <= ready_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                last_q[b] <= last_d[b];
            end
            for (int c = 0; c < NUM_CORES; c++) begin
                bank_id_q[c] <= bank_id_d[c];
                is_rd_q[c]   <= is_rd_d[c];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (ready_q[c] && is_rd_q[c]) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (bank_id_q[c] == BANK_ID_W'(b)) begin
                        rd_data[c*REG_SIZE +: REG_SIZE] = bank_rdata[b];
                    end
                end
            end
        end
    end

    assign ready = ready_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sh_bank_p #(
            .REG_SIZE (REG_SIZE),
            .WORD_W   (WORD_W)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[b]),
            .re    (bank_re[b]),
            .addr  (bank_addr[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_sh_mem_rr.sv
// Self-checking bench for sh_mem_rr: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-free arbitration model.
module tb_sh_mem_rr;

    localparam int NC = 4;
    localparam int NB = 4;
    localparam int AS = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  enable;
    logic [39:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  ready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [7:0]  en;
        logic [39:0] ad;
        logic [31:0] wd;
        logic [3:0]  exp_ready;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    sh_mem_rr #(
        .NUM_CORES (4),
        .NUM_BANKS (4),
        .REG_SIZE  (8),
        .WORD_W    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pack_addr(input int b, input int w);
        return {2'(b), 8'(w)};
    endfunction

    task automatic setCore(input int c, input logic [1:0] en, input int b, input int w,
                           input logic [7:0] d);
        enable[2*c +: 2]   = en;
        addr[AS*c +: AS]   = pack_addr(b, w);
        wr_data[8*c +: 8]  = d;
    endtask

    task automatic clearAll();
        enable  = '0;
        addr    = '0;
        wr_data = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        enable  = v.en;
        addr    = v.ad;
        wr_data = v.wd;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_ready,
                               input logic [31:0] exp_rd, input logic [31:0] mask);
        checks++;
        if (ready !== exp_ready || (rd_data & mask) !== (exp_rd & mask)) begin
            failures++;
            $display("[TB] FAIL %s: ready=%b expected=%b rd_data=%h expected=%h (mask %h)",
                     name, ready, exp_ready, rd_data, exp_rd, mask);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearAll();
        stepCycle();
        checkOutput("reset_state", 4'b0000, 32'h0, '1);
        reset = 1'b0;
    endtask

    // Reference model state for the randomized phase.
    logic [7:0] mem_m [NB][4];
    bit         val_m [NB][4];
    int         last_m [NB];
    bit         rdy_m [NC];
    bit         act [NC];
    bit         is_wr [NC];
    int         rb [NC];
    int         rw [NC];
    logic [7:0] rdat [NC];

    task automatic runRandom(input int cycles);
        logic [3:0]  nxt;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        int          best;
        int          bestd;
        int          d;
        int          op;
        for (int b = 0; b < NB; b++) begin
            last_m[b] = NC - 1;
            for (int w = 0; w < 4; w++) val_m[b][w] = 1'b0;
        end
        for (int c = 0; c < NC; c++) begin
            rdy_m[c] = 1'b0;
            act[c]   = 1'b0;
        end
        for (int n = 0; n < cycles; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (!act[c]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        op       = int'($urandom_range(0, 2));
                        act[c]   = 1'b1;
                        is_wr[c] = (op != 0);
                        rb[c]    = int'($urandom_range(0, NB - 1));
                        rw[c]    = int'($urandom_range(0, 3));
                        rdat[c]  = 8'($urandom);
                        setCore(c, (op == 0) ? 2'b01 : ((op == 1) ? 2'b10 : 2'b11),
                                rb[c], rw[c], rdat[c]);
                    end else begin
                        setCore(c, 2'b00, 0, 0, 8'h00);
                    end
                end
            end
            nxt    = '0;
            exp_rd = '0;
            mask   = '1;
            for (int b = 0; b < NB; b++) begin
                best  = -1;
                bestd = NC;
                for (int c = 0; c < NC; c++) begin
                    if (act[c] && rb[c] == b && !rdy_m[c]) begin
                        d = (c - last_m[b] - 1 + 2 * NC) % NC;
                        if (d < bestd) begin
                            bestd = d;
                            best  = c;
                        end
                    end
                end
                if (best >= 0) begin
                    nxt[best] = 1'b1;
                    last_m[b] = best;
                    if (is_wr[best]) begin
                        mem_m[b][rw[best]] = rdat[best];
                        val_m[b][rw[best]] = 1'b1;
                    end else begin
                        for (int c = 0; c < NC; c++) begin
                            if (act[c] && rb[c] == b && !rdy_m[c] && !is_wr[c]
                                && rw[c] == rw[best]) begin
`ifdef SH_MEM_BCAST_EN
                                nxt[c] = 1'b1;
`endif
                                if (nxt[c]) begin
                                    if (val_m[b][rw[best]]) exp_rd[8*c +: 8] = mem_m[b][rw[best]];
                                    else mask[8*c +: 8] = 8'h00;
                                end
                            end
                        end
                    end
                end
            end
            stepCycle();
            checkOutput("random", nxt, exp_rd, mask);
            for (int c = 0; c < NC; c++) begin
                rdy_m[c] = nxt[c];
                if (nxt[c]) act[c] = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clearAll();
        stepCycle();
        stepCycle();
        checkOutput("reset_init", 4'b0000, 32'h0, '1);
        reset = 1'b0;

        vecs[0] = '{"wr_b1w3", 8'b0000_0010, {30'h0, pack_addr(1, 3)}, 32'h0000005A, 4'b0001, 32'h0};
        vecs[1] = '{"idle_a", 8'h00, 40'h0, 32'h0, 4'b0000, 32'h0};
        vecs[2] = '{"rd_b1w3", 8'b0000_0001, {30'h0, pack_addr(1, 3)}, 32'h0, 4'b0001, 32'h0000005A};
        vecs[3] = '{"idle_b", 8'h00, 40'h0, 32'h0, 4'b0000, 32'h0};
        vecs[4] = '{"par_wr", 8'b1011_1010,
                    {pack_addr(3, 5), pack_addr(2, 5), pack_addr(1, 5), pack_addr(0, 5)},
                    32'h73727177, 4'b1111, 32'h0};
        vecs[5] = '{"idle_c", 8'h00, 40'h0, 32'h0, 4'b0000, 32'h0};
        vecs[6] = '{"par_rd", 8'b0101_0101,
                    {pack_addr(3, 5), pack_addr(2, 5), pack_addr(1, 5), pack_addr(0, 5)},
                    32'h0, 4'b1111, 32'h73727177};
        vecs[7] = '{"idle_d", 8'h00, 40'h0, 32'h0, 4'b0000, 32'h0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput(vecs[i].name, vecs[i].exp_ready, vecs[i].exp_rd, '1);
        end

        // All cores write the same word; each drops its request once it sees ready.
        doReset();
        for (int c = 0; c < NC; c++) setCore(c, 2'b10, 2, 7, 8'(8'h10 + c));
        for (int k = 0; k < NC; k++) begin
            stepCycle();
            checkOutput($sformatf("rr_order%0d", k), 4'(1 << k), 32'h0, '1);
            setCore(k, 2'b00, 0, 0, 8'h00);
        end
        setCore(0, 2'b01, 2, 7, 8'h00);
        stepCycle();
        checkOutput("rr_final_rd", 4'b0001, 32'h00000013, '1);
        clearAll();
        stepCycle();

        doReset();
        setCore(1, 2'b01, 0, 5, 8'h00);
        setCore(3, 2'b01, 0, 5, 8'h00);
        stepCycle();
`ifdef SH_MEM_BCAST_EN
        checkOutput("bcast_rd", 4'b1010, 32'h77007700, '1);
        clearAll();
`else
        checkOutput("same_rd_first", 4'b0010, 32'h00007700, '1);
        setCore(1, 2'b00, 0, 0, 8'h00);
        stepCycle();
        checkOutput("same_rd_second", 4'b1000, 32'h77000000, '1);
        clearAll();
`endif
        stepCycle();
        checkOutput("after_same_rd", 4'b0000, 32'h0, '1);

        // Move bank 1's pointer to core 1, then reset over a granted write.
        doReset();
        setCore(1, 2'b01, 1, 3, 8'h00);
        stepCycle();
        checkOutput("pre_rst_rd", 4'b0010, 32'h00005A00, '1);
        setCore(1, 2'b00, 0, 0, 8'h00);
        setCore(0, 2'b10, 1, 3, 8'hA5);
        #6;
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_write", 4'b0000, 32'h0, '1);
        clearAll();
        reset = 1'b0;
        setCore(0, 2'b01, 1, 3, 8'h00);
        setCore(2, 2'b01, 1, 4, 8'h00);
        stepCycle();
        checkOutput("rst_ptr_first", 4'b0001, 32'h0000005A, '1);
        setCore(0, 2'b00, 0, 0, 8'h00);
        stepCycle();
        checkOutput("rst_ptr_second", 4'b0100, 32'h0, 32'hFF00FFFF);
        clearAll();
        stepCycle();

        setCore(0, 2'b01, 0, 5, 8'h00);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("hold_rd%0d", k), (k % 2 == 1) ? 4'b0001 : 4'b0000,
                        (k % 2 == 1) ? 32'h00000077 : 32'h0, '1);
            stepCycle();
        end
        clearAll();

        doReset();
        runRandom(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
